teclado_display_arbiter: RTL

Shares the single keypad decoder and the single 6-digit display between the `operacional` and `setup` blocks. It grants exactly one owner at a time, based on the setup request level and the setup-done pulse. On every ownership change it inserts a guard window that suppresses keypad traffic and blanks the display, so no keystroke leaks across owners. A setup inactivity timeout forces ownership back to `operacional`. The block sits between `decodificador_de_teclado`/`display` and the two client FSMs.

---
 rtl/teclado_display_arbiter_if.sv | 51 +++++
 rtl/teclado_display_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/teclado_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : teclado_display_arbiter_if
//  Purpose  : Keypad and display bus shared between the arbiter and its
//             clients (operacional, setup, decoder, display).
//  Revision : 1.0 - initial release
// ============================================================================
interface teclado_display_arbiter_if #(
    parameter int KB_W   = 24,
    parameter int DISP_W = 24
) ();
    // ownership control
    logic              req_setup;
    logic              setup_done;
    // keypad side
    logic              kb_en_op;
    logic              kb_valid;
    logic [KB_W-1:0]   kb_value;
    logic              kb_en;
    logic [KB_W-1:0]   dig_value;
    logic              op_valid;
    logic              setup_valid;
    // display side
    logic              disp_en_op;
    logic              disp_en_setup;
    logic [DISP_W-1:0] disp_pac_op;
    logic [DISP_W-1:0] disp_pac_setup;
    logic              disp_en;
    logic [DISP_W-1:0] disp_pac;
    // status
    logic              owner;
    logic              switching;
    logic              setup_timeout;

    // arbiter view
    modport slave (
        input  req_setup, setup_done, kb_en_op, kb_valid, kb_value,
               disp_en_op, disp_en_setup, disp_pac_op, disp_pac_setup,
        output kb_en, dig_value, op_valid, setup_valid,
               disp_en, disp_pac, owner, switching, setup_timeout
    );

    // environment / client view
    modport master (
        output req_setup, setup_done, kb_en_op, kb_valid, kb_value,
               disp_en_op, disp_en_setup, disp_pac_op, disp_pac_setup,
        input  kb_en, dig_value, op_valid, setup_valid,
               disp_en, disp_pac, owner, switching, setup_timeout
    );
endinterface
`default_nettype wire

// File: rtl/teclado_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : teclado_display_arbiter
//  Purpose  : Grants the keypad decoder and 6-digit display to either the
//             operacional or the setup client, with a blanking guard window
//             on every handoff and an inactivity timeout on setup ownership.
//  Revision : 1.0 - initial release
// ============================================================================
module teclado_display_arbiter #(
    parameter int GUARD_CYCLES   = 1000,
    parameter int TIMEOUT_CYCLES = 1_500_000_000,
    parameter int KB_W           = 24,
    parameter int DISP_W         = 24
) (
    input  wire logic               clk,
    input  wire logic               rst,     // asynchronous, active-low
    teclado_display_arbiter_if.slave bus
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OP      = 2'd0,
        ST_GUARD_S = 2'd1,
        ST_SETUP   = 2'd2,
        ST_GUARD_O = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [GW-1:0]       r_guard_cnt;
    logic [IW-1:0]       r_idle_cnt;
    logic                r_rearm;

    logic                w_guard_load;
    logic                w_guard_dec;
    logic                w_idle_clear;
    logic                w_idle_inc;
    logic                w_timeout_exit;
    logic                w_deliver_op;
    logic                w_deliver_setup;

    logic                r_kb_en;
    logic [KB_W-1:0]     r_dig_value;
    logic                r_op_valid;
    logic                r_setup_valid;
    logic                r_disp_en;
    logic [DISP_W-1:0]   r_disp_pac;
    logic                r_owner;
    logic                r_switching;
    logic                r_setup_timeout;

    // Next-state and counter-control decision for the current cycle.
    always_comb begin
        w_next_state   = r_state;
        w_guard_load   = 1'b0;
        w_guard_dec    = 1'b0;
        w_idle_clear   = 1'b0;
        w_idle_inc     = 1'b0;
        w_timeout_exit = 1'b0;
        case (r_state)
            ST_OP: begin
                if (bus.req_setup && r_rearm) begin
                    w_next_state = ST_GUARD_S;
                    w_guard_load = 1'b1;
                end
            end
            ST_GUARD_S: begin
                // A withdrawn request aborts the handoff with a full guard back.
                if (!bus.req_setup) begin
                    w_next_state = ST_GUARD_O;
                    w_guard_load = 1'b1;
                end else if (r_guard_cnt == '0) begin
                    w_next_state = ST_SETUP;
                    w_idle_clear = 1'b1;
                end else begin
                    w_guard_dec = 1'b1;
                end
            end
            ST_SETUP: begin
                // A normal exit outranks the timeout, so no timeout pulse then.
                if (bus.setup_done || !bus.req_setup) begin
                    w_next_state = ST_GUARD_O;
                    w_guard_load = 1'b1;
                end else if (!bus.kb_valid && (r_idle_cnt == IDLE_LAST)) begin
                    w_next_state   = ST_GUARD_O;
                    w_guard_load   = 1'b1;
                    w_timeout_exit = 1'b1;
                end else if (bus.kb_valid) begin
                    w_idle_clear = 1'b1;
                end else begin
                    w_idle_inc = 1'b1;
                end
            end
            default: begin // ST_GUARD_O
                if (r_guard_cnt == '0) begin
                    w_next_state = ST_OP;
                end else begin
                    w_guard_dec = 1'b1;
                end
            end
        endcase
    end

    // Operacional keys only pass while it keeps ownership; a setup key
    // accepted in its last owned cycle is still delivered.
    assign w_deliver_op    = (r_state == ST_OP) && (w_next_state == ST_OP) && bus.kb_valid;
    assign w_deliver_setup = (r_state == ST_SETUP) && bus.kb_valid;

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_OP;
            r_guard_cnt     <= '0;
            r_idle_cnt      <= '0;
            r_rearm         <= 1'b1;
            r_kb_en         <= 1'b0;
            r_dig_value     <= '0;
            r_op_valid      <= 1'b0;
            r_setup_valid   <= 1'b0;
            r_disp_en       <= 1'b0;
            r_disp_pac      <= '0;
            r_owner         <= 1'b0;
            r_switching     <= 1'b0;
            r_setup_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_guard_load) begin
                r_guard_cnt <= GUARD_LOAD;
            end else if (w_guard_dec) begin
                r_guard_cnt <= r_guard_cnt - GW'(1);
            end

            if (w_idle_clear) begin
                r_idle_cnt <= '0;
            end else if (w_idle_inc) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end

            if (w_timeout_exit) begin
                r_rearm <= 1'b0;
            end else if (!bus.req_setup) begin
                r_rearm <= 1'b1;
            end

            r_op_valid      <= w_deliver_op;
            r_setup_valid   <= w_deliver_setup;
            r_setup_timeout <= w_timeout_exit;
            if (w_deliver_op || w_deliver_setup) begin
                r_dig_value <= bus.kb_value;
            end

            case (w_next_state)
                ST_OP: begin
                    r_kb_en     <= bus.kb_en_op;
                    r_disp_en   <= bus.disp_en_op;
                    r_disp_pac  <= bus.disp_pac_op;
                    r_owner     <= 1'b0;
                    r_switching <= 1'b0;
                end
                ST_SETUP: begin
                    r_kb_en     <= 1'b1;
                    r_disp_en   <= bus.disp_en_setup;
                    r_disp_pac  <= bus.disp_pac_setup;
                    r_owner     <= 1'b1;
                    r_switching <= 1'b0;
                end
                default: begin
                    r_kb_en     <= 1'b0;
                    r_disp_en   <= 1'b0;
                    r_disp_pac  <= '0;
                    r_owner     <= 1'b0;
                    r_switching <= 1'b1;
                end
            endcase
        end
    end

    assign bus.kb_en         = r_kb_en;
    assign bus.dig_value     = r_dig_value;
    assign bus.op_valid      = r_op_valid;
    assign bus.setup_valid   = r_setup_valid;
    assign bus.disp_en       = r_disp_en;
    assign bus.disp_pac      = r_disp_pac;
    assign bus.owner         = r_owner;
    assign bus.switching     = r_switching;
    assign bus.setup_timeout = r_setup_timeout;

endmodule
`default_nettype wire
